dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep controller that sits directly upstream of the DDS phase-accumulator stage and drives its 32-bit tuning word (ADDER).
- Steps ADDER from f_start toward f_stop in increments of f_step, holding each value for a programmable dwell time.
- Supports single up, single down, continuous sawtooth and triangular ping-pong sweeps.
- Start/abort pulses control it; busy, done and step_tick report status.

Parameters:
W, 32, tuning-word width; must match the accumulator ADDER width.
DWELL_W, 16, dwell counter width.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  one-cycle pulse; stops the sweep
mode  in  2  00 single up, 01 single down, 10 continuous up (sawtooth), 11 triangle
f_start  in  W  first tuning word
f_stop  in  W  end tuning word
f_step  in  W  step size; 0 is treated as 1
dwell  in  DWELL_W  clocks per value; 0 is treated as 1 (dwell_eff)
ADDER  out  W  tuning word to the phase accumulator, registered
busy  out  1  high while a sweep is running
done  out  1  one-cycle pulse when a single sweep completes
step_tick  out  1  one-cycle pulse in the cycle ADDER takes a new value

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). All outputs are registered.
- RESET, including mid-sweep, takes effect at the next edge: state IDLE, ADDER=0, busy=0, done=0, step_tick=0, direction=up.
- States: IDLE, RUN.
- IDLE:
  - ADDER holds its last value.
  - On start (with abort low), at that same edge:
    - latch mode/f_start/f_stop/f_step/dwell into shadow registers;
    - ADDER=f_start, step_tick=1, busy=1;
    - dwell counter=dwell_eff-1; direction=down for mode 01, up otherwise;
    - go to RUN.
- RUN:
  - Counter decrements each cycle. When the counter is 0, evaluate the next value and reload the counter with dwell_eff-1.
  - Every value, including the first and the last, is held exactly dwell_eff cycles.
- Up step:
  - nxt = ADDER + step, computed at W+1 bits.
  - If carry or nxt >= f_stop: ADDER=f_stop (endpoint reached). Otherwise ADDER=nxt.
- Down step, single-down mode:
  - nxt = ADDER - step.
  - If borrow or nxt <= f_stop: ADDER=f_stop (endpoint).
- Down step, triangle mode:
  - Compare against f_start instead of f_stop.
  - If borrow or nxt <= f_start: ADDER=f_start, direction=up.
- Endpoint actions:
  - Modes 00/01: after f_stop has dwelled dwell_eff cycles → go to IDLE, busy=0, done=1 for one cycle. ADDER holds f_stop.
  - Mode 10: after f_stop dwells → ADDER=f_start, step_tick=1; sweep continues indefinitely.
  - Mode 11: reaching f_stop sets direction=down. The sweep never terminates on its own.
- Wrong ordering is not special-cased (e.g. up mode with f_start > f_stop): the first evaluation clamps to f_stop, giving sequence f_start, f_stop, done. Triangle mode with f_start >= f_stop alternates f_start, f_stop.
- abort:
  - Highest priority after RESET.
  - In RUN → IDLE at the next edge, busy=0, ADDER holds its current value, no done pulse, no step_tick.
  - Ignored in IDLE. Simultaneous start+abort in IDLE: start is ignored.
- start while busy is ignored. Input changes while busy have no effect (shadowed).
- step_tick asserts for every ADDER change, including the initial load and the wrap in mode 10. done and step_tick are never high in the same cycle.

Decomposition:
- Shared package dds_pkg: constant W=32; mode encodings MODE_UP, MODE_DOWN, MODE_SAW, MODE_TRI; state encoding IDLE/RUN. The downstream phase-accumulator stage also uses the mode constants.
- One sub-module dds_dwell_cnt: loadable DWELL_W down-counter with a zero flag (inputs load, load_val; output tc).

Test Plan:
- Mode 00, f_start=100, f_stop=130, f_step=10, dwell=2, start at edge N → ADDER 100@N, 110@N+2, 120@N+4, 130@N+6; done=1 and busy=0 @N+8; step_tick pulses 4 times.
- Mode 00, f_start=0xFFFF_FFF0, f_stop=0xFFFF_FFFF, f_step=0x20, dwell=1 → ADDER 0xFFFF_FFF0 then 0xFFFF_FFFF (carry clamp), then done; no wrap to a small value.
- Mode 01, f_start=5, f_stop=0, f_step=3, dwell=1 → ADDER 5, 2, 0 (borrow clamp), then done.
- Mode 11, f_start=0, f_stop=20, f_step=8, dwell=1 → ADDER 0, 8, 16, 20, 12, 4, 0, 8, …; busy stays 1, no done.
- Mode 10, 0→10, step 5, dwell=1 → ADDER 0, 5, 10, 0, 5, …; then abort at ADDER=5 → busy=0 next edge, ADDER holds 5, no done.
- RESET asserted mid-sweep → next edge ADDER=0, busy=0; a start pulse during busy and a dwell=0 run (behaves as dwell=1) are both checked.

Source files
------------

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared constants for the DDS sweep controller and the downstream
// phase-accumulator stage: tuning-word width, sweep mode encodings and the
// sweep FSM state type.
// -----------------------------------------------------------------------------
package dds_pkg;

   localparam int W = 32;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_SAW  = 2'b10;
   localparam logic [1:0] MODE_TRI  = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/dds_dwell_cnt.sv
// -----------------------------------------------------------------------------
// dds_dwell_cnt
// Loadable down-counter that times how long each tuning word is held.
// Counts down to zero and parks there; tc flags the zero (terminal) count.
//
// Ports:
//   CLK       system clock
//   RESET     synchronous, active-high reset (count -> 0)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load
//   tc        high while the count is zero
// -----------------------------------------------------------------------------
module dds_dwell_cnt #(
   parameter int DWELL_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               tc
);

   localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   logic [DWELL_W-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep controller driving the DDS accumulator tuning word (ADDER).
// Steps ADDER from f_start toward f_stop by f_step, holding each value for
// dwell clocks. Modes: single up, single down, sawtooth, triangle.
//
// Ports:
//   CLK, RESET   system clock, synchronous active-high reset
//   start        pulse, starts a sweep from IDLE (ignored together with abort)
//   abort        pulse, stops a running sweep, ADDER holds
//   mode         sweep mode (dds_pkg MODE_*)
//   f_start      first tuning word
//   f_stop       end tuning word
//   f_step       step size (0 behaves as 1)
//   dwell        clocks per value (0 behaves as 1)
//   ADDER        registered tuning word
//   busy         sweep running
//   done         one-cycle pulse when a single sweep completes
//   step_tick    one-cycle pulse whenever ADDER takes a new value
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no sweep; ADDER holds last value; waiting for start
// RUN   | sweeping; dwell counter times each value, tc triggers next value
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int W       = dds_pkg::W,
   parameter int DWELL_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [W-1:0]       f_start,
   input  logic [W-1:0]       f_stop,
   input  logic [W-1:0]       f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [W-1:0]       ADDER,
   output logic               busy,
   output logic               done,
   output logic               step_tick
);

   localparam logic [W-1:0]       ONE_W = {{(W-1){1'b0}}, 1'b1};
   localparam logic [DWELL_W-1:0] ONE_D = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [W-1:0]       adder_q, adder_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tick_q, tick_d;
   logic               dir_dn_q, dir_dn_d;
   logic               at_end_q, at_end_d;

   // shadow copies of the configuration, frozen for the whole sweep
   logic [1:0]         mode_s, mode_sd;
   logic [W-1:0]       fstart_s, fstart_sd;
   logic [W-1:0]       fstop_s, fstop_sd;
   logic [W-1:0]       fstep_s, fstep_sd;
   logic [DWELL_W-1:0] dwell_m1_s, dwell_m1_sd;

   logic               cnt_load;
   logic [DWELL_W-1:0] cnt_val;
   logic               tc;

   logic [W-1:0]       step_eff;
   logic [DWELL_W-1:0] dwell_m1_in;
   logic [W:0]         sum;
   logic [W:0]         diff;
   logic               up_hit;
   logic               dn_hit_stop;
   logic               dn_hit_start;

   dds_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
      .CLK      (CLK),
      .RESET    (RESET),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (tc)
   );

   assign step_eff    = (fstep_s == '0) ? ONE_W : fstep_s;
   assign dwell_m1_in = (dwell == '0) ? '0 : (dwell - ONE_D);

   // extra MSB captures carry (up) / borrow (down) so clamping catches wrap
   assign sum          = {1'b0, adder_q} + {1'b0, step_eff};
   assign diff         = {1'b0, adder_q} - {1'b0, step_eff};
   assign up_hit       = sum[W]  | (sum[W-1:0]  >= fstop_s);
   assign dn_hit_stop  = diff[W] | (diff[W-1:0] <= fstop_s);
   assign dn_hit_start = diff[W] | (diff[W-1:0] <= fstart_s);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         adder_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tick_q     <= 1'b0;
         dir_dn_q   <= 1'b0;
         at_end_q   <= 1'b0;
         mode_s     <= MODE_UP;
         fstart_s   <= '0;
         fstop_s    <= '0;
         fstep_s    <= '0;
         dwell_m1_s <= '0;
      end else begin
         state_q    <= state_d;
         adder_q    <= adder_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tick_q     <= tick_d;
         dir_dn_q   <= dir_dn_d;
         at_end_q   <= at_end_d;
         mode_s     <= mode_sd;
         fstart_s   <= fstart_sd;
         fstop_s    <= fstop_sd;
         fstep_s    <= fstep_sd;
         dwell_m1_s <= dwell_m1_sd;
      end
   end

   always_comb begin
      state_d     = state_q;
      adder_d     = adder_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tick_d      = 1'b0;
      dir_dn_d    = dir_dn_q;
      at_end_d    = at_end_q;
      mode_sd     = mode_s;
      fstart_sd   = fstart_s;
      fstop_sd    = fstop_s;
      fstep_sd    = fstep_s;
      dwell_m1_sd = dwell_m1_s;
      cnt_load    = 1'b0;
      cnt_val     = dwell_m1_s;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               mode_sd     = mode;
               fstart_sd   = f_start;
               fstop_sd    = f_stop;
               fstep_sd    = f_step;
               dwell_m1_sd = dwell_m1_in;
               adder_d     = f_start;
               tick_d      = 1'b1;
               busy_d      = 1'b1;
               dir_dn_d    = (mode == MODE_DOWN);
               at_end_d    = 1'b0;
               cnt_load    = 1'b1;
               cnt_val     = dwell_m1_in;
               state_d     = RUN;
            end
         end

         RUN: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (tc) begin
               cnt_load = 1'b1;
               case (mode_s)
                  MODE_UP, MODE_DOWN: begin
                     if (at_end_q) begin
                        // endpoint has completed its dwell
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end else begin
                        tick_d = 1'b1;
                        if (!dir_dn_q) begin
                           if (up_hit) begin
                              adder_d  = fstop_s;
                              at_end_d = 1'b1;
                           end else begin
                              adder_d = sum[W-1:0];
                           end
                        end else begin
                           if (dn_hit_stop) begin
                              adder_d  = fstop_s;
                              at_end_d = 1'b1;
                           end else begin
                              adder_d = diff[W-1:0];
                           end
                        end
                     end
                  end

                  MODE_SAW: begin
                     tick_d = 1'b1;
                     if (at_end_q) begin
                        adder_d  = fstart_s;
                        at_end_d = 1'b0;
                     end else if (up_hit) begin
                        adder_d  = fstop_s;
                        at_end_d = 1'b1;
                     end else begin
                        adder_d = sum[W-1:0];
                     end
                  end

                  default: begin
                     // triangle: turn around at both ends, never terminates
                     tick_d = 1'b1;
                     if (!dir_dn_q) begin
                        if (up_hit) begin
                           adder_d  = fstop_s;
                           dir_dn_d = 1'b1;
                        end else begin
                           adder_d = sum[W-1:0];
                        end
                     end else begin
                        if (dn_hit_start) begin
                           adder_d  = fstart_s;
                           dir_dn_d = 1'b0;
                        end else begin
                           adder_d = diff[W-1:0];
                        end
                     end
                  end
               endcase
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ADDER     = adder_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step_tick = tick_q;

endmodule
